// File: rtl/keypad_pkg.sv
// Shared scan states, the no-key marker and key-code sizing for the keypad scanner.
package keypad_pkg;

  localparam logic [0:0] ST_DRIVE = 1'b0;
  localparam logic [0:0] ST_EVAL  = 1'b1;

  typedef enum logic [0:0] {
    DRIVE = ST_DRIVE,
    EVAL  = ST_EVAL
  } scan_state_t;

  // Widest candidate is 7 bits (8x8 matrix); users keep the low KW+1 bits, all ones.
  localparam logic [7:0] KEY_NONE = '1;

  function automatic int key_width(input int cols, input int rows);
    return $clog2(cols * rows);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Matrix pins plus key-event handshake; master is the scanner, slave is the matrix/consumer side.
interface keypad_scanner_if
  import keypad_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int NUM_ROWS = 4
) ();

  localparam int KW = key_width(NUM_COLS, NUM_ROWS);

  logic [NUM_COLS-1:0] colunas;
  logic [NUM_ROWS-1:0] linhas;
  logic [KW-1:0]       key_code;
  logic                key_valid;
  logic                key_ack;
  logic                overrun;
  logic                multi_err;

  modport master (
    input  linhas, key_ack,
    output colunas, key_code, key_valid, overrun, multi_err
  );

  modport slave (
    output linhas, key_ack,
    input  colunas, key_code, key_valid, overrun, multi_err
  );

endinterface

// File: rtl/keypad_debounce.sv
// Frame-rate debounce: accepts a candidate after DEBOUNCE_SCANS identical frames, strobes press in that EVAL.
// KEYPAD_REPEAT_EN adds an auto-repeat strobe every REPEAT_FRAMES frames while a key stays held.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int KW             = 4,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_FRAMES  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        eval,
  input  logic [KW:0] cand,
  output logic [KW:0] stable,
  output logic        press,
  output logic        rpt
);

  localparam logic [KW:0] NONE = KEY_NONE[KW:0];
  localparam int          DW   = $clog2(DEBOUNCE_SCANS + 1);

  logic [KW:0]   last_cand;
  logic [DW-1:0] cnt;
  logic          settled;

  // True only on the EVAL where the run length first reaches DEBOUNCE_SCANS.
  assign settled = eval && (cand == last_cand) && (cnt == DW'(DEBOUNCE_SCANS - 1));
  assign press   = settled && (cand != NONE) && (cand != stable);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_cand <= NONE;
      cnt       <= '0;
      stable    <= NONE;
    end else if (eval) begin
      if (cand == last_cand) begin
        if (cnt != DW'(DEBOUNCE_SCANS))
          cnt <= cnt + 1'b1;
      end else begin
        last_cand <= cand;
        cnt       <= DW'(1);
      end
      if (settled)
        stable <= cand;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);

  logic [RW-1:0] rcnt;
  logic          released;

  assign released = settled && (cand == NONE);
  assign rpt      = eval && !press && !released && (stable != NONE) &&
                    (rcnt == RW'(REPEAT_FRAMES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rcnt <= '0;
    else if (eval) begin
      if (press || released || (stable == NONE) || rpt)
        rcnt <= '0;
      else
        rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: one-hot column drive, frame capture, ghost rejection, debounce, valid/ack event out.
// Event DEBOUNCE_SCANS frames after press; an unacked event drops newer ones (overrun). Repeat: KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_FRAMES  = 64
) (
  input logic              clock,
  input logic              reset,
  keypad_scanner_if.master kp
);

  localparam int          KW    = key_width(NUM_COLS, NUM_ROWS);
  localparam int          CANDW = KW + 1;
  localparam int          NK    = NUM_COLS * NUM_ROWS;
  localparam int          CW    = $clog2(NUM_COLS);
  localparam int          SW    = $clog2(SETTLE_CYCLES);
  localparam logic [KW:0] NONE  = KEY_NONE[KW:0];

  scan_state_t   state;
  logic          run;
  logic [CW-1:0] col;
  logic [SW-1:0] settle;
  logic [NK-1:0] frame;

  logic [1:0]    ones;
  logic [KW:0]   first_idx;
  logic [KW:0]   cand;
  logic [KW:0]   stable;
  logic          press;
  logic          rpt;
  logic          evt;
  logic [KW-1:0] evt_code;

  // run holds the scan off for the first cycle after reset so column 0 gets its full settle time.
  assign kp.colunas = (run && state == DRIVE) ? (NUM_COLS'(1) << col) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= DRIVE;
      run    <= 1'b0;
      col    <= '0;
      settle <= '0;
      frame  <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        case (state)
          DRIVE: begin
            if (settle == SW'(SETTLE_CYCLES - 1)) begin
              frame[col*NUM_ROWS +: NUM_ROWS] <= kp.linhas;
              settle <= '0;
              if (col == CW'(NUM_COLS - 1))
                state <= EVAL;
              else
                col <= col + 1'b1;
            end else begin
              settle <= settle + 1'b1;
            end
          end
          EVAL: begin
            state <= DRIVE;
            col   <= '0;
          end
          default: state <= DRIVE;
        endcase
      end
    end
  end

  // ones saturates at 2: anything above a single key is a ghosting risk and is rejected.
  always_comb begin
    ones      = 2'd0;
    first_idx = NONE;
    for (int i = 0; i < NK; i++) begin
      if (frame[i]) begin
        if (ones == 2'd0)
          first_idx = CANDW'(i);
        if (ones != 2'd2)
          ones = ones + 2'd1;
      end
    end
    cand = (ones == 2'd1) ? first_idx : NONE;
  end

  keypad_debounce #(
    .KW             (KW),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_FRAMES  (REPEAT_FRAMES)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .eval   (state == EVAL),
    .cand   (cand),
    .stable (stable),
    .press  (press),
    .rpt    (rpt)
  );

  assign evt      = press | rpt;
  assign evt_code = press ? cand[KW-1:0] : stable[KW-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.overrun   <= 1'b0;
      kp.multi_err <= 1'b0;
    end else begin
      if (state == EVAL && ones == 2'd2)
        kp.multi_err <= 1'b1;
      if (evt) begin
        if (!kp.key_valid || kp.key_ack) begin
          kp.key_code  <= evt_code;
          kp.key_valid <= 1'b1;
        end else begin
          kp.overrun <= 1'b1;
        end
      end else if (kp.key_valid && kp.key_ack) begin
        kp.key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: 4x4 matrix, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3 (9-clock frames).
// Key-set table, hand sequences for reset corners, then random frames against a frame-level model.
module tb_keypad_scanner;

  localparam int NC    = 4;
  localparam int NR    = 4;
  localparam int DS    = 3;
  localparam int FRAME = 9;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] keys;
  logic [3:0]  m_linhas;

  int vectors     = 0;
  int miscompares = 0;

  // Frame-level reference model state (-1 means no key).
  int m_last, m_run, m_stable, m_code;
  bit m_valid, m_over, m_multi;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          ack;     // 0 none, 1 pulse early in last frame, 2 pulse in last EVAL cycle
    logic        v;
    int          code;
    logic        o;
    logic        m;
  } vec_t;

  vec_t tbl [23];

  keypad_scanner_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) kp ();

  keypad_scanner #(
    .NUM_COLS       (NC),
    .NUM_ROWS       (NR),
    .SETTLE_CYCLES  (2),
    .DEBOUNCE_SCANS (DS),
    .REPEAT_FRAMES  (64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clock = ~clock;

  // Passive matrix: a held key connects its column drive to its row line.
  always_comb begin
    m_linhas = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (kp.colunas[c] && keys[c*NR + r])
          m_linhas[r] = 1'b1;
  end
  assign kp.linhas = m_linhas;

  task automatic check_bits(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic ev, input int ec, input logic eo, input logic em);
    logic [3:0] ec4;
    ec4 = ec[3:0];
    vectors++;
    if (kp.key_valid !== ev || kp.key_code !== ec4 || kp.overrun !== eo || kp.multi_err !== em) begin
      miscompares++;
      $display("FAIL %s: got valid=%b code=%0d overrun=%b multi=%b expected valid=%b code=%0d overrun=%b multi=%b",
               name, kp.key_valid, kp.key_code, kp.overrun, kp.multi_err, ev, ec4, eo, em);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    keys       = '0;
    kp.key_ack = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Called just after a frame-start edge; returns just after the edge closing the frame's EVAL.
  task automatic run_frame(input logic [15:0] k, input int ack_mode);
    keys = k;
    for (int c = 1; c <= FRAME; c++) begin
      kp.key_ack = (ack_mode == 1 && c == 2) || (ack_mode == 2 && c == FRAME);
      @(posedge clock);
      #1;
    end
    kp.key_ack = 1'b0;
  endtask

  task automatic model_reset();
    m_last = -1; m_run = 0; m_stable = -1; m_code = 0;
    m_valid = 0; m_over = 0; m_multi = 0;
  endtask

  task automatic model_frame(input logic [15:0] k, input int a);
    int n;
    int cand;
    bit ev;
    n    = $countones(k);
    cand = -1;
    ev   = 0;
    if (a == 1 && m_valid) m_valid = 0;
    if (n == 1)
      for (int i = 0; i < 16; i++) if (k[i]) cand = i;
    if (n > 1) m_multi = 1;
    if (cand == m_last) m_run++;
    else begin
      m_last = cand;
      m_run  = 1;
    end
    if (m_run == DS) begin
      if (cand >= 0 && cand != m_stable) begin
        ev       = 1;
        m_stable = cand;
      end else if (cand < 0) begin
        m_stable = -1;
      end
    end
    if (ev) begin
      if (!m_valid || a == 2) begin
        m_code  = cand;
        m_valid = 1;
      end else begin
        m_over = 1;
      end
    end else if (m_valid && a == 2) begin
      m_valid = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] cur;
    int          hold;
    int          a;
    int          r;
    logic [3:0]  exp_col;

    tbl[0]  = '{16'h0000, 2, 0, 1'b0, 0,  1'b0, 1'b0};
    tbl[1]  = '{16'h0400, 2, 0, 1'b0, 0,  1'b0, 1'b0};
    tbl[2]  = '{16'h0400, 1, 0, 1'b1, 10, 1'b0, 1'b0};
    tbl[3]  = '{16'h0400, 1, 1, 1'b0, 10, 1'b0, 1'b0};
    tbl[4]  = '{16'h0400, 3, 0, 1'b0, 10, 1'b0, 1'b0};
    tbl[5]  = '{16'h0000, 3, 0, 1'b0, 10, 1'b0, 1'b0};
    tbl[6]  = '{16'h0020, 2, 0, 1'b0, 10, 1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 1, 0, 1'b0, 10, 1'b0, 1'b0};
    tbl[8]  = '{16'h0020, 3, 0, 1'b1, 5,  1'b0, 1'b0};
    tbl[9]  = '{16'h0020, 1, 1, 1'b0, 5,  1'b0, 1'b0};
    tbl[10] = '{16'h0000, 3, 0, 1'b0, 5,  1'b0, 1'b0};
    tbl[11] = '{16'h8001, 4, 0, 1'b0, 5,  1'b0, 1'b1};
    tbl[12] = '{16'h0000, 3, 0, 1'b0, 5,  1'b0, 1'b1};
    tbl[13] = '{16'h0008, 3, 0, 1'b1, 3,  1'b0, 1'b1};
    tbl[14] = '{16'h0000, 3, 0, 1'b1, 3,  1'b0, 1'b1};
    tbl[15] = '{16'h0080, 2, 0, 1'b1, 3,  1'b0, 1'b1};
    tbl[16] = '{16'h0080, 1, 2, 1'b1, 7,  1'b0, 1'b1};
    tbl[17] = '{16'h0080, 1, 1, 1'b0, 7,  1'b0, 1'b1};
    tbl[18] = '{16'h0000, 3, 0, 1'b0, 7,  1'b0, 1'b1};
    tbl[19] = '{16'h0008, 3, 0, 1'b1, 3,  1'b0, 1'b1};
    tbl[20] = '{16'h0000, 3, 0, 1'b1, 3,  1'b0, 1'b1};
    tbl[21] = '{16'h0080, 3, 0, 1'b1, 3,  1'b1, 1'b1};
    tbl[22] = '{16'h0000, 1, 1, 1'b0, 3,  1'b1, 1'b1};

    // Reset values and idle column sequence.
    reset      = 1'b1;
    keys       = '0;
    kp.key_ack = 1'b0;
    @(posedge clock);
    #1;
    check_state("reset outputs", 1'b0, 0, 1'b0, 1'b0);
    check_bits("reset colunas", {4'b0, kp.colunas}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_bits("colunas before first edge", {4'b0, kp.colunas}, 8'h00);
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      exp_col = ((n % FRAME) < 8) ? (4'b0001 << ((n % FRAME) / 2)) : 4'b0000;
      check_bits($sformatf("idle scan cycle %0d", n),
                 {1'b0, kp.key_valid, kp.overrun, kp.multi_err, kp.colunas},
                 {4'b0000, exp_col});
    end

    do_reset();
    for (int i = 0; i < 23; i++) begin
      for (int f = 0; f < tbl[i].frames; f++)
        run_frame(tbl[i].keys, (f == tbl[i].frames - 1) ? tbl[i].ack : 0);
      check_state($sformatf("table[%0d]", i), tbl[i].v, tbl[i].code, tbl[i].o, tbl[i].m);
    end

    // Reset asserted while column 2 of a pressed frame is driven.
    for (int f = 0; f < DS; f++) run_frame(16'h0400, 0);
    check_state("press 10 before reset", 1'b1, 10, 1'b1, 1'b1);
    keys = 16'h0400;
    repeat (4) @(posedge clock);
    #1;
    check_bits("column 2 driven", {4'b0, kp.colunas}, 8'h04);
    #2;
    reset = 1'b1;
    #1;
    check_state("async reset outputs", 1'b0, 0, 1'b0, 1'b0);
    check_bits("async reset colunas", {4'b0, kp.colunas}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_bits("scan restarts at col 0", {4'b0, kp.colunas}, 8'h01);
    run_frame(16'h0400, 0);
    check_state("re-debounce frame 1", 1'b0, 0, 1'b0, 1'b0);
    run_frame(16'h0400, 0);
    check_state("re-debounce frame 2", 1'b0, 0, 1'b0, 1'b0);
    run_frame(16'h0400, 0);
    check_state("re-debounce frame 3", 1'b1, 10, 1'b0, 1'b0);

    // Random frames against the model.
    do_reset();
    model_reset();
    hold = 0;
    cur  = '0;
    for (int f = 0; f < 90; f++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        if (r < 3)      cur = '0;
        else if (r < 9) cur = 16'(1) << $urandom_range(0, 15);
        else            cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        hold = $urandom_range(1, 5);
      end
      hold--;
      if ($urandom_range(0, 3) == 0)      a = 1;
      else if ($urandom_range(0, 5) == 0) a = 2;
      else                                a = 0;
      run_frame(cur, a);
      model_frame(cur, a);
      check_state($sformatf("random frame %0d", f), m_valid, m_code, m_over, m_multi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
